// File: rtl/sd_block_arbiter.sv
// sd_block_arbiter: round-robin sharing of the SD block transfer interface between NREQ drive requesters.
module sd_block_arbiter #(
  parameter int NREQ    = 3,
  parameter int LBA_W   = 32,
  parameter int TIMEOUT = 1048576
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_rd,
  input  logic [NREQ-1:0]       req_wr,
  input  logic [NREQ*LBA_W-1:0] req_lba,
  input  logic [NREQ-1:0]       req_mounted,
  input  logic [NREQ-1:0]       sd_ack,
  output logic [LBA_W-1:0]      sd_lba,
  output logic [NREQ-1:0]       sd_rd,
  output logic [NREQ-1:0]       sd_wr,
  output logic                  cpu_wait,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic [NREQ-1:0]       req_done,
  output logic [NREQ-1:0]       req_err
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, XFER} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d, ack_q;
  logic [NREQ-1:0] sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [NREQ-1:0] req_done_q, req_done_d, req_err_q, req_err_d, clr_rd, clr_wr;
  logic [2:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d, win, idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [LBA_W-1:0] sd_lba_q, sd_lba_d;
  logic cpu_wait_q, cpu_wait_d, busy_q, busy_d, found, win_rd, win_mnt, ack_rise, ack_fall;
  logic [7:0] cand, oh_win, oh_gnt;
  logic [LBA_W-1:0] lba_arr [8];
  // Widen per-requester vectors to 8 so a 3-bit index never needs truncation
  for (genvar g = 0; g < 8; g++) begin : g_lba
    if (g < NREQ) begin : g_used
      assign lba_arr[g] = req_lba[g*LBA_W +: LBA_W];
    end else begin : g_pad
      assign lba_arr[g] = '0;
    end
  end
  assign cand   = 8'(pend_rd_q | pend_wr_q);
  assign oh_gnt = 8'd1 << grant_id_q;
  assign ack_rise = |(oh_gnt & 8'(sd_ack) & ~8'(ack_q));
  assign ack_fall = |(oh_gnt & ~8'(sd_ack) & 8'(ack_q));
  always_comb begin
    found = 1'b0;
    win = rr_ptr_q;
    idx = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == 3'(NREQ-1)) ? 3'd0 : idx + 3'd1;
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    oh_win = 8'd1 << win;
    win_rd = |(oh_win & 8'(pend_rd_q));
    win_mnt = |(oh_win & 8'(req_mounted));
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_id_d = grant_id_q;
    timer_d = timer_q;
    sd_lba_d = sd_lba_q;
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    req_done_d = '0;
    req_err_d = '0;
    clr_rd = '0;
    clr_wr = '0;
    case (state_q)
      IDLE: if (found) begin
        grant_id_d = win;
        rr_ptr_d = win;
        clr_rd = win_rd ? NREQ'(oh_win) : '0;
        clr_wr = win_rd ? '0 : NREQ'(oh_win);
        if (!win_mnt) req_err_d = NREQ'(oh_win);
        else begin
          sd_lba_d = lba_arr[win];
          sd_rd_d = clr_rd;
          sd_wr_d = clr_wr;
          timer_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: if (ack_rise) begin
        sd_rd_d = '0;
        sd_wr_d = '0;
        state_d = XFER;
      end else if (timer_q == TW'(TIMEOUT-1)) begin
        sd_rd_d = '0;
        sd_wr_d = '0;
        req_err_d = NREQ'(oh_gnt);
        state_d = IDLE;
      end else timer_d = timer_q + 1'b1;
      XFER: if (ack_fall) begin
        req_done_d = NREQ'(oh_gnt);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    pend_rd_d = (pend_rd_q & ~clr_rd) | req_rd;
    pend_wr_d = (pend_wr_q & ~clr_wr) | req_wr;
    busy_d = state_d != IDLE;
    cpu_wait_d = (|pend_rd_d) || (|pend_wr_d) || busy_d;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
      ack_q <= '0;
      rr_ptr_q <= 3'(NREQ-1);
      grant_id_q <= '0;
      timer_q <= '0;
      sd_lba_q <= '0;
      sd_rd_q <= '0;
      sd_wr_q <= '0;
      req_done_q <= '0;
      req_err_q <= '0;
      cpu_wait_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      ack_q <= sd_ack;
      rr_ptr_q <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      timer_q <= timer_d;
      sd_lba_q <= sd_lba_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      req_done_q <= req_done_d;
      req_err_q <= req_err_d;
      cpu_wait_q <= cpu_wait_d;
      busy_q <= busy_d;
    end
  end
  assign sd_lba = sd_lba_q;
  assign sd_rd = sd_rd_q;
  assign sd_wr = sd_wr_q;
  assign cpu_wait = cpu_wait_q;
  assign busy = busy_q;
  assign grant_id = grant_id_q;
  assign req_done = req_done_q;
  assign req_err = req_err_q;
endmodule

// File: tb/tb_sd_block_arbiter.sv
// tb_sd_block_arbiter: directed checks of grant order, handshake timing, errors and reset.
module tb_sd_block_arbiter;
  logic clk_sys = 1'b0, reset = 1'b1;
  logic [2:0] req_rd = '0, req_wr = '0, req_mounted = 3'b111, sd_ack = '0;
  logic [95:0] req_lba = {32'h0000_00C2, 32'h0000_1234, 32'h0000_00A0};
  logic [31:0] sd_lba;
  logic [2:0] sd_rd, sd_wr, grant_id, req_done, req_err;
  logic cpu_wait, busy;
  logic [31:0] lbas [3] = '{32'h0000_00A0, 32'h0000_1234, 32'h0000_00C2};
  int errors = 0, checks = 0, cnt;

  sd_block_arbiter #(.NREQ(3), .LBA_W(32), .TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .req_mounted(req_mounted), .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .cpu_wait(cpu_wait), .busy(busy), .grant_id(grant_id), .req_done(req_done), .req_err(req_err));

  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait for a strobe, check it, then ack rise/fall and expect the done pulse
  task automatic serve(input int idx, input bit wr, input string tag);
    int n = 0;
    logic [2:0] oh;
    oh = 3'b001 << idx;
    while ((sd_rd | sd_wr) == 3'b000 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_rd"}, sd_rd, wr ? 3'b000 : oh);
    chk({tag, "_wr"}, sd_wr, wr ? oh : 3'b000);
    chk({tag, "_lba"}, sd_lba, lbas[idx]);
    chk({tag, "_gid"}, grant_id, idx);
    chk({tag, "_wait"}, cpu_wait, 1);
    sd_ack[idx] = 1'b1;
    tick();
    chk({tag, "_drop"}, sd_rd | sd_wr, 0);
    tick();
    sd_ack[idx] = 1'b0;
    tick();
    chk({tag, "_done"}, req_done, oh);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_strobe", {sd_rd, sd_wr}, 0);
    chk("rst_flags", {cpu_wait, busy, grant_id, req_done, req_err}, 0);
    chk("rst_lba", sd_lba, 0);
    reset = 1'b0;
    tick();
    chk("idle_wait", cpu_wait, 0);

    // single read with exact cycle timing
    req_rd = 3'b010;
    tick();
    req_rd = '0;
    chk("sr_wait_t1", cpu_wait, 1);
    chk("sr_rd_t1", sd_rd, 0);
    tick();
    chk("sr_rd_t2", sd_rd, 3'b010);
    chk("sr_lba_t2", sd_lba, 32'h1234);
    chk("sr_busy_t2", busy, 1);
    tick(); tick(); tick();
    sd_ack = 3'b010;
    tick();
    chk("sr_rd_t6", sd_rd, 0);
    chk("sr_busy_t6", busy, 1);
    tick(); tick(); tick();
    sd_ack = '0;
    chk("sr_wait_t9", cpu_wait, 1);
    tick();
    chk("sr_done_t10", req_done, 3'b010);
    chk("sr_err_t10", req_err, 0);
    tick();
    chk("sr_done_t11", req_done, 0);
    chk("sr_wait_t11", cpu_wait, 0);
    chk("sr_busy_t11", busy, 0);
    chk("sr_lba_hold", sd_lba, 32'h1234);

    // round-robin from reset pointer
    do_reset();
    req_rd = 3'b111;
    tick();
    req_rd = '0;
    serve(0, 0, "rr1_a");
    serve(1, 0, "rr1_b");
    serve(2, 0, "rr1_c");
    req_rd = 3'b111;
    tick();
    req_rd = '0;
    serve(0, 0, "rr2_a");
    serve(1, 0, "rr2_b");
    serve(2, 0, "rr2_c");
    req_rd = 3'b001;
    tick();
    req_rd = '0;
    serve(0, 0, "rr3_pre");
    req_rd = 3'b101;
    tick();
    req_rd = '0;
    serve(2, 0, "rr3_a");
    serve(0, 0, "rr3_b");

    // read and write on the same requester
    req_rd = 3'b100;
    req_wr = 3'b100;
    tick();
    req_rd = '0;
    req_wr = '0;
    serve(2, 0, "rw_rd");
    chk("rw_wait_mid", cpu_wait, 1);
    serve(2, 1, "rw_wr");
    tick();
    chk("rw_wait_end", cpu_wait, 0);

    // unmounted requester
    req_mounted = 3'b110;
    req_wr = 3'b001;
    tick();
    req_wr = '0;
    chk("um_wait_t1", cpu_wait, 1);
    chk("um_err_t1", req_err, 0);
    tick();
    chk("um_err_t2", req_err, 3'b001);
    chk("um_wait_t2", cpu_wait, 0);
    chk("um_wr_t2", sd_wr, 0);
    tick();
    chk("um_err_t3", req_err, 0);
    chk("um_wr_t3", sd_wr, 0);
    req_mounted = 3'b111;

    // timeout with a request arriving during the wait
    req_rd = 3'b010;
    tick();
    req_rd = '0;
    tick();
    chk("to_rd_t2", sd_rd, 3'b010);
    cnt = 0;
    while (sd_rd == 3'b010 && cnt < 40) begin
      req_rd = (cnt == 3) ? 3'b001 : 3'b000;
      tick();
      cnt++;
    end
    req_rd = '0;
    chk("to_len", cnt, 16);
    chk("to_err", req_err, 3'b010);
    chk("to_done", req_done, 0);
    serve(0, 0, "to_next");

    // reset in the middle of a transfer with another request pending
    req_rd = 3'b001;
    tick();
    req_rd = '0;
    tick();
    chk("rx_rd", sd_rd, 3'b001);
    req_rd = 3'b100;
    sd_ack = 3'b001;
    tick();
    req_rd = '0;
    chk("rx_xfer", sd_rd, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rx_out", {sd_rd, sd_wr, grant_id, req_done, req_err}, 0);
    chk("rx_flags", {cpu_wait, busy}, 0);
    chk("rx_lba", sd_lba, 0);
    sd_ack = '0;
    tick();
    chk("rx_nodone", {req_done, req_err}, 0);
    tick(); tick(); tick();
    chk("rx_lost", {sd_rd, sd_wr, cpu_wait, busy}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
